ps2_packet_framer: RTL and testbench

Parametrised successor to the fixed 3-byte PS/2 mouse packet assembler. Accepts a byte stream with a per-byte valid strobe and aligns to packets on a sync bit. Assembles 3- to BYTES_MAX-byte packets; packet length is selectable per packet, so the same block handles standard 3-byte and IntelliMouse 4-byte packets. Holds each completed packet in an output register under a valid/ready handshake, aborts stalled packets on timeout, and counts sync errors. Sits between the PS/2 byte receiver and the mouse-event decoder.

---
 rtl/ps2_packet_framer.sv | 188 ++++++++++++++++++
 tb/tb_ps2_packet_framer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_packet_framer.sv
`default_nettype none
// ============================================================================
// Module   : ps2_packet_framer
// Purpose  : Aligns a PS/2 byte stream to packets on a sync bit. Assembles
//            3..BYTES_MAX byte packets and presents them under valid/ready.
//            Stalled packets are aborted on timeout, and sync errors are counted.
// Revision : 1.0  initial release
// ============================================================================
module ps2_packet_framer #(
  parameter int BYTE_W    = 8,
  parameter int BYTES_MAX = 4,
  parameter int SYNC_BIT  = 3,
  parameter int TIMEOUT   = 1000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic [BYTE_W-1:0]           in,
  input  logic [3:0]                  pkt_len,
  output logic [BYTES_MAX*BYTE_W-1:0] out_bytes,
  output logic [3:0]                  out_len,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        overflow,
  output logic                        timeout_err,
  output logic [15:0]                 sync_err_cnt
);

  localparam int          c_OUT_W   = BYTES_MAX * BYTE_W;
  localparam int          c_TMR_W   = $clog2(TIMEOUT + 1);
  localparam logic [3:0]  c_MAX_LEN = 4'(BYTES_MAX);
  localparam logic [3:0]  c_MIN_LEN = 4'd3;

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_COLLECT = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [3:0]           r_idx;
  logic [3:0]           r_len;
  logic [c_TMR_W-1:0]   r_timer;
  logic [BYTE_W-1:0]    r_buf [BYTES_MAX];

  logic                 w_start;
  logic                 w_discard;
  logic                 w_store;
  logic                 w_complete;
  logic                 w_timeout;
  logic [3:0]           w_len_clamp;
  logic [BYTE_W-1:0]    w_cur [BYTES_MAX];
  logic [c_OUT_W-1:0]   w_packed;

  logic [c_OUT_W-1:0]   r_out_bytes;
  logic [3:0]           r_out_len;
  logic                 r_out_valid;
  logic                 r_overflow;
  logic                 r_timeout_err;
  logic [15:0]          r_sync_err_cnt;

  // Requested length limited to the supported 3..BYTES_MAX range
  always_comb begin
    w_len_clamp = pkt_len;
    if (pkt_len < c_MIN_LEN)      w_len_clamp = c_MIN_LEN;
    else if (pkt_len > c_MAX_LEN) w_len_clamp = c_MAX_LEN;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next-state and control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_discard   = 1'b0;
    w_store     = 1'b0;
    w_complete  = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          if (in[SYNC_BIT]) begin
            w_start     = 1'b1;
            w_state_nxt = S_COLLECT;
          end else begin
            w_discard   = 1'b1;
          end
        end
      end
      S_COLLECT: begin
        if (in_valid) begin
          w_store = 1'b1;
          if (r_idx == r_len - 4'd1) begin
            w_complete  = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end else if (r_timer == c_TMR_W'(TIMEOUT - 1)) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Buffer view with the byte arriving this cycle merged in at position idx
  always_comb begin
    for (int i = 0; i < BYTES_MAX; i++) begin
      w_cur[i] = (4'(i) == r_idx) ? in : r_buf[i];
    end
  end

  // Pack the first len bytes MSB-first into the low bits, upper bytes zero
  always_comb begin
    w_packed = '0;
    for (int i = 0; i < BYTES_MAX; i++) begin
      if (4'(i) < r_len) w_packed = (w_packed << BYTE_W) | c_OUT_W'(w_cur[i]);
    end
  end

  // Byte buffer, index counter, latched length and inter-byte idle timer
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_idx   <= '0;
      r_len   <= '0;
      r_timer <= '0;
      for (int i = 0; i < BYTES_MAX; i++) r_buf[i] <= '0;
    end else if (w_start) begin
      r_buf[0] <= in;
      r_len    <= w_len_clamp;
      r_idx    <= 4'd1;
      r_timer  <= '0;
    end else if (w_store) begin
      for (int i = 0; i < BYTES_MAX; i++) begin
        if (4'(i) == r_idx) r_buf[i] <= in;
      end
      r_timer <= '0;
      r_idx   <= w_complete ? 4'd0 : r_idx + 4'd1;
    end else if (r_state == S_COLLECT) begin
      if (w_timeout) begin
        r_timer <= '0;
        r_idx   <= '0;
      end else begin
        r_timer <= r_timer + c_TMR_W'(1);
      end
    end
  end

  // Output holding register, event pulses and saturating error counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_out_bytes    <= '0;
      r_out_len      <= '0;
      r_out_valid    <= 1'b0;
      r_overflow     <= 1'b0;
      r_timeout_err  <= 1'b0;
      r_sync_err_cnt <= '0;
    end else begin
      r_overflow    <= 1'b0;
      r_timeout_err <= w_timeout;
      if (w_complete && (!r_out_valid || out_ready)) begin
        r_out_bytes <= w_packed;
        r_out_len   <= r_len;
        r_out_valid <= 1'b1;
      end else if (w_complete) begin
        r_overflow  <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      if ((w_discard || w_timeout) && (r_sync_err_cnt != 16'hFFFF)) begin
        r_sync_err_cnt <= r_sync_err_cnt + 16'd1;
      end
    end
  end

  assign out_bytes    = r_out_bytes;
  assign out_len      = r_out_len;
  assign out_valid    = r_out_valid;
  assign overflow     = r_overflow;
  assign timeout_err  = r_timeout_err;
  assign sync_err_cnt = r_sync_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ps2_packet_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_packet_framer
// Purpose  : Scoreboard bench for ps2_packet_framer (directed + random stimulus)
// Revision : 1.0  initial release
// ============================================================================
module tb_ps2_packet_framer;

  localparam int BW = 8;
  localparam int BM = 4;
  localparam int TO = 10;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic [BW-1:0]   in_b;
  logic [3:0]      pkt_len;
  logic            out_ready;
  logic [BM*BW-1:0] out_bytes;
  logic [3:0]      out_len;
  logic            out_valid;
  logic            overflow;
  logic            timeout_err;
  logic [15:0]     sync_err_cnt;

  ps2_packet_framer #(.BYTE_W(BW), .BYTES_MAX(BM), .SYNC_BIT(3), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_b), .pkt_len(pkt_len),
    .out_bytes(out_bytes), .out_len(out_len), .out_valid(out_valid),
    .out_ready(out_ready), .overflow(overflow), .timeout_err(timeout_err),
    .sync_err_cnt(sync_err_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state: bytes of the packet in progress, its length, idle time
  int          m_q[$];
  int          m_len  = 3;
  int          m_idle = 0;
  bit          m_held = 0;
  int          m_cnt  = 0;
  int          exp_ovf = 0;
  int          exp_to  = 0;
  int          obs_ovf = 0;
  int          obs_to  = 0;
  logic [31:0] sb_bytes[$];
  logic [3:0]  sb_len[$];
  logic [31:0] seen[$];
  logic [3:0]  seen_len[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Apply the rules to the inputs that the next rising edge will sample
  task automatic model_step();
    bit          done;
    logic [31:0] pk;
    int          pl;
    done = 0;
    pk   = 0;
    pl   = 0;
    if (!reset) begin
      m_q.delete();
      m_idle = 0;
      m_held = 0;
      m_cnt  = 0;
      sb_bytes.delete();
      sb_len.delete();
      return;
    end
    if (m_q.size() == 0) begin
      if (in_valid) begin
        if (in_b[3]) begin
          m_q.push_back(int'(in_b));
          m_len  = (pkt_len < 3) ? 3 : ((pkt_len > BM) ? BM : int'(pkt_len));
          m_idle = 0;
        end else if (m_cnt < 65535) begin
          m_cnt++;
        end
      end
    end else begin
      if (in_valid) begin
        m_q.push_back(int'(in_b));
        m_idle = 0;
        if (m_q.size() == m_len) begin
          done = 1;
          foreach (m_q[i]) pk = (pk << 8) | 32'(m_q[i]);
          pl = m_len;
          m_q.delete();
        end
      end else begin
        m_idle++;
        if (m_idle == TO) begin
          m_q.delete();
          m_idle = 0;
          if (m_cnt < 65535) m_cnt++;
          exp_to++;
        end
      end
    end
    if (done) begin
      if (!m_held || out_ready) begin
        sb_bytes.push_back(pk);
        sb_len.push_back(4'(pl));
        m_held = 1;
      end else begin
        exp_ovf++;
      end
    end else if (out_ready) begin
      m_held = 0;
    end
  endtask

  task automatic cyc(input bit v, input logic [7:0] b, input logic [3:0] l, input bit r);
    in_valid  = v;
    in_b      = b;
    pkt_len   = l;
    out_ready = r;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic [3:0] l, input bit r);
    cyc(1'b1, b, l, r);
  endtask

  task automatic idle(input int n, input bit r);
    for (int k = 0; k < n; k++) cyc(1'b0, 8'h00, 4'd3, r);
  endtask

  // Monitor: count pulses and pop the scoreboard on every handshake
  always @(negedge clk) begin
    if (reset) begin
      if (overflow)    obs_ovf++;
      if (timeout_err) obs_to++;
      if (out_valid && out_ready) begin
        if (sb_bytes.size() == 0) begin
          chk("unexpected_packet", out_bytes, 32'hxxxxxxxx);
        end else begin
          chk("pkt_bytes", out_bytes, sb_bytes.pop_front());
          chk("pkt_len", {28'd0, out_len}, {28'd0, sb_len.pop_front()});
        end
        seen.push_back(out_bytes);
        seen_len.push_back(out_len);
      end
    end
  end

  int ovf0;
  int to0;
  logic [15:0] cnt0;
  logic [7:0]  rb;

  initial begin
    reset = 1'b0;
    idle(2, 1'b0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_bytes", out_bytes, 32'd0);
    chk("rst_out_len", {28'd0, out_len}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
    chk("rst_sync_err_cnt", {16'd0, sync_err_cnt}, 32'd0);
    reset = 1'b1;

    // Two 3-byte packets, second back-to-back
    seen.delete(); seen_len.delete();
    send(8'h08, 4'd3, 1); send(8'h01, 4'd3, 1); send(8'h02, 4'd3, 1);
    send(8'h38, 4'd3, 1); send(8'hFF, 4'd3, 1); send(8'hFE, 4'd3, 1);
    idle(2, 1);
    chk("b2b_count", seen.size(), 2);
    chk("b2b_pkt0", seen[0], 32'h00080102);
    chk("b2b_pkt1", seen[1], 32'h0038FFFE);
    chk("b2b_len0", {28'd0, seen_len[0]}, 32'd3);

    // Sync errors before alignment
    seen.delete(); seen_len.delete();
    send(8'h00, 4'd3, 1); send(8'h37, 4'd3, 1); send(8'h08, 4'd3, 1);
    send(8'h03, 4'd3, 1); send(8'h04, 4'd3, 1);
    idle(2, 1);
    chk("sync_cnt", {16'd0, sync_err_cnt}, 32'd2);
    chk("sync_count", seen.size(), 1);
    chk("sync_pkt", seen[0], 32'h00080304);

    // Length 4 and clamped length 9
    seen.delete(); seen_len.delete();
    send(8'h08, 4'd4, 1); send(8'h01, 4'd4, 1); send(8'h02, 4'd4, 1); send(8'h03, 4'd4, 1);
    send(8'h08, 4'd9, 1); send(8'h01, 4'd9, 1); send(8'h02, 4'd9, 1); send(8'h03, 4'd9, 1);
    idle(2, 1);
    chk("len4_count", seen.size(), 2);
    chk("len4_pkt", seen[0], 32'h08010203);
    chk("len4_len", {28'd0, seen_len[0]}, 32'd4);
    chk("len9_pkt", seen[1], 32'h08010203);
    chk("len9_len", {28'd0, seen_len[1]}, 32'd4);

    // Backpressure: second completion is dropped
    seen.delete(); seen_len.delete();
    ovf0 = obs_ovf;
    send(8'h08, 4'd3, 0); send(8'h01, 4'd3, 0); send(8'h02, 4'd3, 0);
    send(8'h18, 4'd3, 0); send(8'h05, 4'd3, 0); send(8'h06, 4'd3, 0);
    chk("bp_ovf_pulse", {31'd0, overflow}, 32'd1);
    idle(2, 0);
    chk("bp_ovf_count", obs_ovf - ovf0, 1);
    chk("bp_hold_bytes", out_bytes, 32'h00080102);
    chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
    idle(1, 1);
    chk("bp_drained", {31'd0, out_valid}, 32'd0);
    idle(1, 0);
    chk("bp_count", seen.size(), 1);
    chk("bp_pkt", seen[0], 32'h00080102);

    // Drain and completion in the same cycle
    seen.delete(); seen_len.delete();
    ovf0 = obs_ovf;
    send(8'h08, 4'd3, 0); send(8'h01, 4'd3, 0); send(8'h02, 4'd3, 0);
    send(8'h18, 4'd3, 0); send(8'h05, 4'd3, 0); send(8'h06, 4'd3, 1);
    chk("sim_valid", {31'd0, out_valid}, 32'd1);
    chk("sim_bytes", out_bytes, 32'h00180506);
    idle(1, 1);
    idle(1, 0);
    chk("sim_no_ovf", obs_ovf - ovf0, 0);
    chk("sim_count", seen.size(), 2);
    chk("sim_pkt1", seen[1], 32'h00180506);

    // Timeout: abort exactly TO edges after the last accepted byte
    seen.delete(); seen_len.delete();
    cnt0 = sync_err_cnt;
    to0  = obs_to;
    send(8'h08, 4'd3, 1); send(8'h01, 4'd3, 1);
    idle(TO - 1, 1);
    chk("to_not_early", {31'd0, timeout_err}, 32'd0);
    idle(1, 1);
    chk("to_pulse", {31'd0, timeout_err}, 32'd1);
    chk("to_cnt", {16'd0, sync_err_cnt}, {16'd0, cnt0 + 16'd1});
    idle(1, 1);
    chk("to_pulse_end", {31'd0, timeout_err}, 32'd0);
    chk("to_obs", obs_to - to0, 1);
    chk("to_no_pkt", seen.size(), 0);

    // Reset mid-packet with a held packet
    send(8'h08, 4'd3, 0); send(8'h01, 4'd3, 0); send(8'h02, 4'd3, 0);
    send(8'h08, 4'd3, 0); send(8'h01, 4'd3, 0);
    reset = 1'b0;
    idle(1, 0);
    reset = 1'b1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_bytes", out_bytes, 32'd0);
    chk("mid_rst_cnt", {16'd0, sync_err_cnt}, 32'd0);
    seen.delete(); seen_len.delete();
    send(8'h08, 4'd3, 1); send(8'h0A, 4'd3, 1); send(8'h0B, 4'd3, 1);
    idle(2, 1);
    chk("post_rst_pkt", seen[0], 32'h00080A0B);

    // Random traffic against the model
    for (int it = 0; it < 600; it++) begin
      if ($urandom_range(0, 24) == 0) begin
        idle($urandom_range(8, 12), 1'($urandom_range(0, 1)));
      end else begin
        rb = 8'($urandom);
        if ($urandom_range(0, 3) != 0) rb[3] = 1'b1;
        cyc(($urandom_range(0, 3) != 0), rb, 4'($urandom_range(0, 15)),
            ($urandom_range(0, 2) != 0));
      end
    end
    idle(12, 1);
    idle(1, 1);
    chk("rnd_sync_cnt", {16'd0, sync_err_cnt}, 32'(m_cnt));
    chk("rnd_ovf", obs_ovf, exp_ovf);
    chk("rnd_to", obs_to, exp_to);
    chk("rnd_sb_empty", sb_bytes.size(), 0);
    chk("rnd_idle_valid", {31'd0, out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global bound so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
